// File: rtl/req_ack_pkg.sv
// Shared types and default widths for the req/ack responder slice.
package req_ack_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } hsk_state_e;

  localparam int CNT_W_DEF    = 4;
  localparam int HSK_W_DEF    = 8;
  localparam int ACK_HOLD_DEF = 1;

endpackage

// File: rtl/step_counter.sv
// Enabled step counter with synchronous clear; wraps modulo 2**CNT_W.
module step_counter import req_ack_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/req_ack_responder.sv
// Target-side req/ack responder with a handshake counter and an enabled step counter.
// Define HSK_PROTO_CHK_EN to build the sticky protocol-error checker driving err.
module req_ack_responder import req_ack_pkg::*; #(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int ACK_HOLD = ACK_HOLD_DEF,
  parameter int HSK_W    = HSK_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             en,
  input  logic             cnt_clr,
  output logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] a,
  output logic [HSK_W-1:0] hsk_cnt,
  output logic             err
);

  localparam int HOLD_W = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(ACK_HOLD - 1);

  hsk_state_e        state;
  logic              req_d;
  logic              rise;
  logic [HOLD_W-1:0] hold_cnt;

  assign rise = req & ~req_d;

  // A rise outside IDLE is deliberately dropped; a fresh handshake needs req seen low first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      ack      <= 1'b0;
      busy     <= 1'b0;
      hold_cnt <= '0;
      hsk_cnt  <= '0;
      req_d    <= 1'b0;
    end else begin
      req_d <= req;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= ACK;
            ack      <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= HOLD_INIT;
            hsk_cnt  <= hsk_cnt + HSK_W'(1);
          end
        end
        ACK: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else begin
            ack <= 1'b0;
            if (req) begin
              state <= WAIT_LOW;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        WAIT_LOW: begin
          if (!req) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          ack   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef HSK_PROTO_CHK_EN
  logic fall;

  assign fall = ~req & req_d;

  // Flags only; the handshake path above is identical with or without the checker.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == ACK && hold_cnt != '0 && fall) || (rise && state != IDLE)) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  step_counter #(.CNT_W(CNT_W)) u_step_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (en),
    .q     (a)
  );

endmodule
